detector_jogada: RTL and testbench

DETECTOR_JOGADA -- requirements
Module: detector_jogada

---
 rtl/detector_jogada_pkg.sv | 26 ++
 rtl/sincronizador_botoes.sv | 31 +++
 rtl/detector_jogada.sv | 125 ++++++++++++
 tb/tb_detector_jogada.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// -----------------------------------------------------------------------------
// detector_jogada_pkg
// Shared game constants: play-detector FSM state codes, the default debounce
// length, and the control-unit state codes used elsewhere in the game.
// No ports (package).
// -----------------------------------------------------------------------------
package detector_jogada_pkg;

   // 1 ms at 50 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;
   localparam int unsigned N_BOTOES_DEFAULT        = 4;

   // Play-detector FSM
   localparam logic [1:0] OCIOSO       = 2'd0;
   localparam logic [1:0] ESTABILIZA   = 2'd1;
   localparam logic [1:0] PULSO        = 2'd2;
   localparam logic [1:0] ESPERA_SOLTA = 2'd3;

   // Control-unit FSM
   localparam logic [2:0] UC_INICIAL       = 3'd0;
   localparam logic [2:0] UC_PREPARA       = 3'd1;
   localparam logic [2:0] UC_ESPERA_JOGADA = 3'd2;
   localparam logic [2:0] UC_COMPARA       = 3'd3;
   localparam logic [2:0] UC_FIM           = 3'd4;

endpackage

// File: rtl/sincronizador_botoes.sv
// -----------------------------------------------------------------------------
// sincronizador_botoes
// N-bit two-flop synchronizer for raw asynchronous button inputs.
// Ports:
//   clock   - system clock
//   reset   - asynchronous reset, active-low (clears both stages)
//   entrada - raw asynchronous inputs
//   saida   - inputs synchronized to clock (two-cycle delay)
// -----------------------------------------------------------------------------
module sincronizador_botoes #(
   parameter int unsigned N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [N-1:0] entrada,
   output logic [N-1:0] saida
);

   logic [N-1:0] estagio1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estagio1 <= '0;
         saida    <= '0;
      end else begin
         estagio1 <= entrada;
         saida    <= estagio1;
      end
   end

endmodule

// File: rtl/detector_jogada.sv
// -----------------------------------------------------------------------------
// detector_jogada
// Debounces the answer buttons and reports one play per press.
// Ports:
//   clock        - system clock, all state changes on rising edge
//   reset        - asynchronous reset, active-low
//   botoes       - raw answer buttons, active-high, asynchronous
//   habilita     - a new press is accepted only while high
//   limpa        - synchronous clear of jogada
//   jogada_feita - one-cycle pulse when a debounced play is accepted
//   jogada       - one-hot code of the last accepted button
//   db_estado    - current FSM state, for debug
// -----------------------------------------------------------------------------
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned N_BOTOES        = N_BOTOES_DEFAULT
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   input  logic                limpa,
   output logic                jogada_feita,
   output logic [N_BOTOES-1:0] jogada,
   output logic [1:0]          db_estado
);

   localparam int unsigned    CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CONT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]          estado;
   logic [N_BOTOES-1:0] bs;
   logic [N_BOTOES-1:0] cand;
   logic [CW-1:0]       contador;
   logic                um_quente;
   logic                estavel;
   logic                fim_contagem;
   logic                carrega_jogada;

   sincronizador_botoes #(
      .N (N_BOTOES)
   ) u_sinc (
      .clock   (clock),
      .reset   (reset),
      .entrada (botoes),
      .saida   (bs)
   );

   always_comb begin
      // exactly one bit set: nonzero and clearing the lowest set bit leaves 0
      um_quente    = (bs != '0) && ((bs & (bs - 1'b1)) == '0);
      estavel      = habilita && (bs == cand);
      fim_contagem = (contador == CONT_MAX);
      // jogada is loaded on the edge entering PULSO and again while in PULSO,
      // so a limpa overlapping either edge cannot erase the new play
      carrega_jogada = ((estado == ESTABILIZA) && estavel && fim_contagem) ||
                       (estado == PULSO);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado   <= OCIOSO;
         cand     <= '0;
         contador <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (habilita && um_quente) begin
                  cand     <= bs;
                  contador <= '0;
                  estado   <= ESTABILIZA;
               end
            end
            ESTABILIZA: begin
               if (estavel) begin
                  if (fim_contagem) begin
                     contador <= '0;
                     estado   <= PULSO;
                  end else begin
                     contador <= contador + 1'b1;
                  end
               end else begin
                  contador <= '0;
                  estado   <= OCIOSO;
               end
            end
            PULSO: begin
               contador <= '0;
               estado   <= ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
               // counts consecutive all-released cycles; any press restarts it
               if (bs != '0) begin
                  contador <= '0;
               end else if (fim_contagem) begin
                  contador <= '0;
                  estado   <= OCIOSO;
               end else begin
                  contador <= contador + 1'b1;
               end
            end
            default: begin
               contador <= '0;
               estado   <= OCIOSO;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jogada <= '0;
      end else if (carrega_jogada) begin
         jogada <= cand;
      end else if (limpa) begin
         jogada <= '0;
      end
   end

   assign jogada_feita = (estado == PULSO);
   assign db_estado    = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// -----------------------------------------------------------------------------
// tb_detector_jogada
// Self-checking bench for detector_jogada with DEBOUNCE_CYCLES=4, N_BOTOES=4.
// No ports.
// -----------------------------------------------------------------------------
module tb_detector_jogada;

   localparam int unsigned D = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [3:0] botoes;
   logic       habilita;
   logic       limpa;
   logic       jogada_feita;
   logic [3:0] jogada;
   logic [1:0] db_estado;

   int total = 0;
   int bad   = 0;

   detector_jogada #(
      .DEBOUNCE_CYCLES (D),
      .N_BOTOES        (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .habilita     (habilita),
      .limpa        (limpa),
      .jogada_feita (jogada_feita),
      .jogada       (jogada),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   // Reference model: two-sample delay on the buttons, then run-length rules.
   logic [3:0] m_s1, m_s2, m_cand, m_jog;
   bit         m_press, m_pulso, m_solta;
   int         m_run;

   task automatic modelo_reset();
      m_s1 = '0; m_s2 = '0; m_cand = '0; m_jog = '0;
      m_press = 0; m_pulso = 0; m_solta = 0; m_run = 0;
   endtask

   task automatic modelo_passo();
      logic [3:0] bs;
      bit carrega;
      bs = m_s2;
      carrega = 0;
      if (m_pulso) begin
         m_pulso = 0; m_solta = 1; m_run = 0; carrega = 1;
      end else if (m_solta) begin
         if (bs != 0) m_run = 0;
         else begin
            m_run++;
            if (m_run == D) begin m_solta = 0; m_run = 0; end
         end
      end else if (m_press) begin
         if (habilita && bs == m_cand) begin
            m_run++;
            if (m_run == D) begin m_press = 0; m_pulso = 1; carrega = 1; end
         end else begin
            m_press = 0;
         end
      end else if (habilita && $countones(bs) == 1) begin
         m_press = 1; m_cand = bs; m_run = 0;
      end
      if (carrega) m_jog = m_cand;
      else if (limpa) m_jog = '0;
      m_s2 = m_s1;
      m_s1 = botoes;
   endtask

   function automatic logic [1:0] modelo_db();
      if (m_press)      return 2'd1;
      else if (m_pulso) return 2'd2;
      else if (m_solta) return 2'd3;
      else              return 2'd0;
   endfunction

   task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
      total++;
      if (atual !== esperado) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
      end
   endtask

   task automatic passo();
      @(posedge clock);
      modelo_passo();
      #1;
   endtask

   typedef struct {
      logic [3:0] b;
      logic       hab;
      logic       lim;
      int         ciclos;
      int         pulsos;
      logic [3:0] jog;
      logic [1:0] db;
   } seg_t;

   seg_t tab [19];

   initial begin
      int np;
      int restante;
      logic [3:0] valor;

      tab[0]  = '{4'b0100, 1'b1, 1'b0, 20, 1, 4'b0100, 2'd3};
      tab[1]  = '{4'b0000, 1'b1, 1'b0,  8, 0, 4'b0100, 2'd0};
      tab[2]  = '{4'b0010, 1'b1, 1'b0,  3, 0, 4'b0100, 2'd1};
      tab[3]  = '{4'b0000, 1'b1, 1'b0,  8, 0, 4'b0100, 2'd0};
      tab[4]  = '{4'b0011, 1'b1, 1'b0, 10, 0, 4'b0100, 2'd0};
      tab[5]  = '{4'b0000, 1'b1, 1'b0,  4, 0, 4'b0100, 2'd0};
      tab[6]  = '{4'b1000, 1'b1, 1'b0, 10, 1, 4'b1000, 2'd3};
      tab[7]  = '{4'b0000, 1'b1, 1'b0,  2, 0, 4'b1000, 2'd3};
      tab[8]  = '{4'b0001, 1'b1, 1'b0, 10, 0, 4'b1000, 2'd3};
      tab[9]  = '{4'b0000, 1'b1, 1'b0, 12, 0, 4'b1000, 2'd0};
      tab[10] = '{4'b0001, 1'b1, 1'b0, 10, 1, 4'b0001, 2'd3};
      tab[11] = '{4'b0000, 1'b1, 1'b0,  8, 0, 4'b0001, 2'd0};
      tab[12] = '{4'b0000, 1'b1, 1'b1,  2, 0, 4'b0000, 2'd0};
      tab[13] = '{4'b0100, 1'b0, 1'b0, 10, 0, 4'b0000, 2'd0};
      tab[14] = '{4'b0100, 1'b1, 1'b0, 10, 1, 4'b0100, 2'd3};
      tab[15] = '{4'b0000, 1'b1, 1'b0,  8, 0, 4'b0100, 2'd0};
      tab[16] = '{4'b0010, 1'b1, 1'b0,  4, 0, 4'b0100, 2'd1};
      tab[17] = '{4'b0010, 1'b0, 1'b0, 10, 0, 4'b0100, 2'd0};
      tab[18] = '{4'b0000, 1'b1, 1'b0,  4, 0, 4'b0100, 2'd0};

      // reset state
      reset = 1'b0; botoes = '0; habilita = 1'b1; limpa = 1'b0;
      modelo_reset();
      #12;
      check("reset feita", 32'(jogada_feita), 0);
      check("reset jogada", 32'(jogada), 0);
      check("reset db", 32'(db_estado), 0);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) passo();

      // latency and state sequence of a held press
      botoes = 4'b0100;
      for (int e = 1; e <= 20; e++) begin
         passo();
         check($sformatf("lat feita e%0d", e), 32'(jogada_feita), (e == 7) ? 1 : 0);
         check($sformatf("lat db e%0d", e), 32'(db_estado),
               (e <= 2) ? 0 : (e <= 6) ? 1 : (e == 7) ? 2 : 3);
         if (e == 7) check("lat jogada", 32'(jogada), 32'h4);
      end
      botoes = '0;
      for (int i = 0; i < 8; i++) passo();

      // table of segments
      for (int i = 0; i < 19; i++) begin
         botoes = tab[i].b; habilita = tab[i].hab; limpa = tab[i].lim;
         np = 0;
         for (int c = 0; c < tab[i].ciclos; c++) begin
            passo();
            if (jogada_feita) np++;
         end
         check($sformatf("seg%0d pulsos", i), 32'(np), 32'(tab[i].pulsos));
         check($sformatf("seg%0d jogada", i), 32'(jogada), 32'(tab[i].jog));
         check($sformatf("seg%0d db", i), 32'(db_estado), 32'(tab[i].db));
      end
      limpa = 1'b0; habilita = 1'b1;

      // reset in the middle of a debounce, button kept held
      botoes = 4'b0010;
      for (int i = 0; i < 4; i++) passo();
      check("mid db before reset", 32'(db_estado), 1);
      #2 reset = 1'b0;
      #1;
      check("mid reset feita", 32'(jogada_feita), 0);
      check("mid reset jogada", 32'(jogada), 0);
      check("mid reset db", 32'(db_estado), 0);
      passo();
      #3 reset = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         passo();
         check($sformatf("rel feita e%0d", e), 32'(jogada_feita), (e == 7) ? 1 : 0);
         if (e == 7) check("rel jogada", 32'(jogada), 32'h2);
      end
      botoes = '0;
      for (int i = 0; i < 8; i++) passo();

      // limpa overlapping PULSO, then a plain limpa
      botoes = 4'b1000;
      for (int e = 1; e <= 10; e++) begin
         limpa = (e >= 7 && e <= 9);
         passo();
         if (e == 7) begin
            check("lp feita e7", 32'(jogada_feita), 1);
            check("lp jogada e7", 32'(jogada), 32'h8);
         end
         if (e == 8) check("lp jogada e8", 32'(jogada), 32'h8);
         if (e == 9) check("limpa clears", 32'(jogada), 0);
         if (e == 10) begin
            check("limpa holds", 32'(jogada), 0);
            check("held no 2nd pulse", 32'(jogada_feita), 0);
         end
      end
      limpa = 1'b0; botoes = '0;
      for (int i = 0; i < 8; i++) passo();

      // randomized stimulus against the model
      reset = 1'b0;
      modelo_reset();
      #3 reset = 1'b1;
      restante = 0;
      valor = '0;
      for (int c = 0; c < 3000; c++) begin
         if (restante == 0) begin
            case ($urandom_range(0, 3))
               0:       valor = '0;
               1, 2:    valor = 4'b0001 << $urandom_range(0, 3);
               default: valor = 4'($urandom);
            endcase
            restante = $urandom_range(1, 14);
         end
         restante--;
         botoes   = valor;
         habilita = ($urandom_range(0, 19) != 0);
         limpa    = ($urandom_range(0, 29) == 0);
         passo();
         check($sformatf("rnd feita c%0d", c), 32'(jogada_feita), 32'(m_pulso));
         check($sformatf("rnd jogada c%0d", c), 32'(jogada), 32'(m_jog));
         check($sformatf("rnd db c%0d", c), 32'(db_estado), 32'(modelo_db()));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
